// File: rtl/fnd_scan_rx_pkg.sv
// Shared constants for the FND scan receiver: segment patterns, special digit codes, frame FSM states.
package fnd_scan_rx_pkg;
  localparam logic [6:0] PAT_0     = 7'h7E;
  localparam logic [6:0] PAT_1     = 7'h30;
  localparam logic [6:0] PAT_2     = 7'h6D;
  localparam logic [6:0] PAT_3     = 7'h79;
  localparam logic [6:0] PAT_4     = 7'h33;
  localparam logic [6:0] PAT_5     = 7'h5B;
  localparam logic [6:0] PAT_6     = 7'h5F;
  localparam logic [6:0] PAT_7     = 7'h70;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h73;
  localparam logic [6:0] PAT_BLANK = 7'h00;

  localparam logic [3:0] DIG_BLANK   = 4'hF;
  localparam logic [3:0] DIG_INVALID = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } frame_state_e;
endpackage

// File: rtl/fnd_scan_rx_pat2bcd.sv
// Combinational segment pattern -> digit code; blank maps to DIG_BLANK, anything else unknown to DIG_INVALID.
module fnd_pat2bcd
  import fnd_scan_rx_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] code_o,
  output logic       bad_o
);

  always_comb begin
    code_o = DIG_INVALID;
    bad_o  = 1'b0;
    case (pat_i)
      PAT_0:     code_o = 4'd0;
      PAT_1:     code_o = 4'd1;
      PAT_2:     code_o = 4'd2;
      PAT_3:     code_o = 4'd3;
      PAT_4:     code_o = 4'd4;
      PAT_5:     code_o = 4'd5;
      PAT_6:     code_o = 4'd6;
      PAT_7:     code_o = 4'd7;
      PAT_8:     code_o = 4'd8;
      PAT_9:     code_o = 4'd9;
      PAT_BLANK: code_o = DIG_BLANK;
      default:   bad_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Receiver for the multiplexed 6-digit FND scan bus: dwell filtering, pattern decode,
// frame assembly and MM:SS -> binary conversion.
module fnd_scan_rx
  import fnd_scan_rx_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_valid,
  output logic [5:0]  o_min,
  output logic [5:0]  o_sec,
  output logic        o_time_ok,
  output logic        o_seg_err,
  output logic        o_enb_err,
  output logic        o_lost
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);

  function automatic logic [5:0] bcd2bin(input logic [3:0] t, input logic [3:0] u);
    return 6'({t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, u});
  endfunction

  function automatic logic time_ok(input logic [15:0] d);
    return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd5) && (d[11:8] <= 4'd9) && (d[15:12] <= 4'd5);
  endfunction

  logic [6:0]    seg_q, prev_seg_q;
  logic          dp_q, prev_dp_q;
  logic [5:0]    enb_q, prev_enb_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q;
  logic [5:0]    mask_q;
  logic [23:0]   dig_q;
  logic [5:0]    dpbuf_q;
  frame_state_e  state_q;

  logic [23:0] digits_q;
  logic [5:0]  dp_out_q, min_q, sec_q;
  logic        frame_valid_q, ok_q, seg_err_q, enb_err_q, lost_q;

  logic       same, onehot, multi, acc, bad;
  logic [2:0] idx;
  logic [3:0] code;

  fnd_pat2bcd u_pat2bcd (
    .pat_i  (seg_q),
    .code_o (code),
    .bad_o  (bad)
  );

  always_comb begin
    same   = (seg_q == prev_seg_q) && (dp_q == prev_dp_q) && (enb_q == prev_enb_q);
    onehot = ($countones(~enb_q) == 1);
    multi  = (enb_q != 6'h3F) && !onehot;
    idx    = 3'd0;
    for (int i = 0; i < 6; i++)
      if (!enb_q[i]) idx = 3'(i);
    // Fires exactly once per dwell: the count then saturates one above this value.
    acc = same && onehot && (cnt_q == CW'(STABLE_CYC - 2));
    cnt_d = cnt_q;
    if (!onehot || !same)
      cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYC - 1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0; prev_seg_q <= '0;
      dp_q <= 1'b0; prev_dp_q <= 1'b0;
      enb_q <= '0; prev_enb_q <= '0;
      cnt_q <= '0; tmo_q <= '0; mask_q <= '0;
      dig_q <= '0; dpbuf_q <= '0;
      state_q <= ST_IDLE;
      digits_q <= '0; dp_out_q <= '0; min_q <= '0; sec_q <= '0; ok_q <= 1'b0;
      frame_valid_q <= 1'b0; seg_err_q <= 1'b0; enb_err_q <= 1'b0; lost_q <= 1'b0;
    end else begin
      seg_q <= i_seg; dp_q <= i_seg_dp; enb_q <= i_seg_enb;
      prev_seg_q <= seg_q; prev_dp_q <= dp_q; prev_enb_q <= enb_q;
      cnt_q <= cnt_d;
      seg_err_q <= acc && bad;
      enb_err_q <= multi && (enb_q != prev_enb_q);
      frame_valid_q <= 1'b0;
      lost_q <= 1'b0;
      if (acc) begin
        dig_q[{idx, 2'b00} +: 4] <= code;
        dpbuf_q[idx] <= dp_q;
      end
      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (acc) begin
            mask_q[idx] <= 1'b1;
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (mask_q == 6'h3F) begin
            state_q <= ST_DONE;
          end else if (acc) begin
            mask_q[idx] <= 1'b1;
            tmo_q <= '0;
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            lost_q <= 1'b1;
            mask_q <= '0;
            tmo_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DONE: begin
          digits_q <= dig_q;
          dp_out_q <= dpbuf_q;
          ok_q  <= time_ok(dig_q[15:0]);
          min_q <= time_ok(dig_q[15:0]) ? bcd2bin(dig_q[15:12], dig_q[11:8]) : 6'd0;
          sec_q <= time_ok(dig_q[15:0]) ? bcd2bin(dig_q[7:4], dig_q[3:0]) : 6'd0;
          frame_valid_q <= 1'b1;
          tmo_q <= '0;
          // A digit landing in this cycle already belongs to the next frame.
          if (acc) begin
            mask_q <= 6'b000001 << idx;
            state_q <= ST_COLLECT;
          end else begin
            mask_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_digits      = digits_q;
  assign o_dp          = dp_out_q;
  assign o_frame_valid = frame_valid_q;
  assign o_min         = min_q;
  assign o_sec         = sec_q;
  assign o_time_ok     = ok_q;
  assign o_seg_err     = seg_err_q;
  assign o_enb_err     = enb_err_q;
  assign o_lost        = lost_q;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Scoreboarded bench for fnd_scan_rx: expected frames are queued as scans are driven and popped on o_frame_valid.
module tb_fnd_scan_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic [23:0] o_digits;
  logic [5:0]  o_dp, o_min, o_sec;
  logic        o_frame_valid, o_time_ok, o_seg_err, o_enb_err, o_lost;

  fnd_scan_rx #(.STABLE_CYC(4), .TIMEOUT_CYC(50)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_seg         (i_seg),
    .i_seg_dp      (i_seg_dp),
    .i_seg_enb     (i_seg_enb),
    .o_digits      (o_digits),
    .o_dp          (o_dp),
    .o_frame_valid (o_frame_valid),
    .o_min         (o_min),
    .o_sec         (o_sec),
    .o_time_ok     (o_time_ok),
    .o_seg_err     (o_seg_err),
    .o_enb_err     (o_enb_err),
    .o_lost        (o_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  mn;
    logic [5:0]  sc;
    logic        ok;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int frame_cnt = 0, seg_cnt = 0, enb_cnt = 0, lost_cnt = 0;

  function automatic logic [6:0] pat(input logic [3:0] c);
    case (c)
      4'd0: return 7'h7E;  4'd1: return 7'h30;  4'd2: return 7'h6D;
      4'd3: return 7'h79;  4'd4: return 7'h33;  4'd5: return 7'h5B;
      4'd6: return 7'h5F;  4'd7: return 7'h70;  4'd8: return 7'h7F;
      4'd9: return 7'h73;  4'hF: return 7'h00;
      default: return 7'h55;
    endcase
  endfunction

  function automatic frame_t model(input logic [23:0] d, input logic [5:0] dp);
    frame_t f;
    int d0, d1, d2, d3;
    d0 = int'(d[3:0]); d1 = int'(d[7:4]); d2 = int'(d[11:8]); d3 = int'(d[15:12]);
    f.digits = d;
    f.dp = dp;
    f.ok = (d0 <= 9) && (d1 <= 5) && (d2 <= 9) && (d3 <= 5);
    f.mn = f.ok ? 6'(d3 * 10 + d2) : 6'd0;
    f.sc = f.ok ? 6'(d1 * 10 + d0) : 6'd0;
    return f;
  endfunction

  always @(negedge clk) begin
    if (o_seg_err) seg_cnt++;
    if (o_enb_err) enb_cnt++;
    if (o_lost) lost_cnt++;
    if (o_frame_valid) begin
      frame_t e;
      frame_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got digits=%h dp=%b, none expected", o_digits, o_dp);
      end else begin
        e = exp_q.pop_front();
        if (o_digits !== e.digits || o_dp !== e.dp || o_min !== e.mn || o_sec !== e.sc ||
            o_time_ok !== e.ok) begin
          errors++;
          $display("FAIL frame_data: got %h/%b min=%0d sec=%0d ok=%b, want %h/%b min=%0d sec=%0d ok=%b",
                   o_digits, o_dp, o_min, o_sec, o_time_ok, e.digits, e.dp, e.mn, e.sc, e.ok);
        end
      end
    end
  end

  task automatic drive_digit(input int n, input logic [6:0] seg, input logic dp, input int hold);
    i_seg = seg;
    i_seg_dp = dp;
    i_seg_enb = ~(6'b000001 << n);
    repeat (hold) @(negedge clk);
  endtask

  task automatic go_idle(input int n);
    i_seg = 7'h00;
    i_seg_dp = 1'b0;
    i_seg_enb = 6'h3F;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] sel);
    for (int i = 0; i < 6; i++)
      if (sel[i]) drive_digit(i, pat(d[i*4 +: 4]), dp[i], 8);
  endtask

  task automatic test_reset;
    int f0, s0, e0, l0;
    rst = 1'b1;
    go_idle(3);
    rst = 1'b0;
    checks++;
    if ({o_digits, o_dp, o_min, o_sec} !== 42'd0) begin
      errors++;
      $display("FAIL reset_data: got digits=%h dp=%b min=%0d sec=%0d, want all 0", o_digits, o_dp, o_min, o_sec);
    end
    checks++;
    if ({o_frame_valid, o_time_ok, o_seg_err, o_enb_err, o_lost} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, want 00000",
               {o_frame_valid, o_time_ok, o_seg_err, o_enb_err, o_lost});
    end
    f0 = frame_cnt; s0 = seg_cnt; e0 = enb_cnt; l0 = lost_cnt;
    go_idle(1000);
    checks++;
    if ((frame_cnt - f0) + (seg_cnt - s0) + (enb_cnt - e0) + (lost_cnt - l0) !== 0) begin
      errors++;
      $display("FAIL idle_pulses: got %0d pulses, want 0",
               (frame_cnt - f0) + (seg_cnt - s0) + (enb_cnt - e0) + (lost_cnt - l0));
    end
  endtask

  task automatic test_frame;
    int f0;
    f0 = frame_cnt;
    exp_q.push_back(model(24'hFF1234, 6'b000100));
    scan(24'hFF1234, 6'b000100, 6'h3F);
    go_idle(4);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout: %0d frames outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (frame_cnt - f0 != 1) begin
      errors++;
      $display("FAIL frame_count: got %0d, want 1", frame_cnt - f0);
    end
    checks++;
    if (o_min !== 6'd12 || o_sec !== 6'd34 || o_time_ok !== 1'b1) begin
      errors++;
      $display("FAIL frame_time: got min=%0d sec=%0d ok=%b, want 12 34 1", o_min, o_sec, o_time_ok);
    end
  endtask

  task automatic test_short_dwell;
    int f0;
    f0 = frame_cnt;
    drive_digit(0, pat(4'd7), 1'b0, 8);
    drive_digit(1, pat(4'd9), 1'b0, 2);
    drive_digit(1, pat(4'd8), 1'b0, 2);
    scan(24'hFF5607, 6'b0, 6'b111100);
    checks++;
    if (frame_cnt - f0 != 0) begin
      errors++;
      $display("FAIL short_dwell_frame: got %0d frames, want 0", frame_cnt - f0);
    end
    exp_q.push_back(model(24'hFF5607, 6'b0));
    drive_digit(1, pat(4'd0), 1'b0, 8);
    go_idle(4);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || frame_cnt - f0 != 1) begin
      errors++;
      $display("FAIL short_dwell_complete: got %0d frames, %0d outstanding, want 1 and 0",
               frame_cnt - f0, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bad_pattern;
    int s0;
    s0 = seg_cnt;
    exp_q.push_back(model(24'hFF1E34, 6'b0));
    scan(24'hFF1E34, 6'b0, 6'h3F);
    go_idle(4);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_pat_frame: %0d frames outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (seg_cnt - s0 != 1) begin
      errors++;
      $display("FAIL seg_err_count: got %0d, want 1", seg_cnt - s0);
    end
    checks++;
    if (o_digits[11:8] !== 4'hE || o_time_ok !== 1'b0 || o_min !== 6'd0) begin
      errors++;
      $display("FAIL bad_pat_hold: got d2=%h ok=%b min=%0d, want e 0 0", o_digits[11:8], o_time_ok, o_min);
    end
  endtask

  task automatic test_enb_err;
    int e0, f0;
    e0 = enb_cnt; f0 = frame_cnt;
    exp_q.push_back(model(24'hFF5959, 6'b0));
    scan(24'hFF5959, 6'b0, 6'b000111);
    i_seg = pat(4'd8);
    i_seg_enb = 6'b111100;
    repeat (10) @(negedge clk);
    scan(24'hFF5959, 6'b0, 6'b111000);
    go_idle(4);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (enb_cnt - e0 != 1) begin
      errors++;
      $display("FAIL enb_err_count: got %0d, want 1", enb_cnt - e0);
    end
    checks++;
    if (exp_q.size() != 0 || frame_cnt - f0 != 1) begin
      errors++;
      $display("FAIL enb_err_frame: got %0d frames, %0d outstanding, want 1 and 0",
               frame_cnt - f0, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout;
    int l0, f0;
    longint t0, t1;
    logic found;
    l0 = lost_cnt; f0 = frame_cnt; found = 1'b0; t1 = 0;
    drive_digit(0, pat(4'd1), 1'b0, 8);
    drive_digit(1, pat(4'd2), 1'b0, 8);
    t0 = longint'($time);
    drive_digit(2, pat(4'd3), 1'b0, 8);
    go_idle(0);
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (o_lost) begin
        found = 1'b1;
        t1 = longint'($time);
      end
    end
    // Accept lands 5 clocks after digit 2 is driven, o_lost 50 clocks after that.
    checks++;
    if (!found || (t1 - t0) / 10 != 55) begin
      errors++;
      $display("FAIL lost_timing: found=%b at %0d cycles, want 1 at 55", found, (t1 - t0) / 10);
    end
    checks++;
    if (frame_cnt - f0 != 0) begin
      errors++;
      $display("FAIL lost_frame: got %0d frames, want 0", frame_cnt - f0);
    end
    exp_q.push_back(model(24'hFF0815, 6'b0));
    scan(24'hFF0815, 6'b0, 6'h3F);
    go_idle(4);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || frame_cnt - f0 != 1 || lost_cnt - l0 != 1) begin
      errors++;
      $display("FAIL after_lost: got frames=%0d lost=%0d outstanding=%0d, want 1 1 0",
               frame_cnt - f0, lost_cnt - l0, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe;
    int l0, f0;
    scan(24'hFF4321, 6'b0, 6'b000111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_digits !== 24'd0 || o_min !== 6'd0 || o_time_ok !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: got digits=%h min=%0d ok=%b, want 0 0 0", o_digits, o_min, o_time_ok);
    end
    l0 = lost_cnt; f0 = frame_cnt;
    scan(24'hFF4321, 6'b0, 6'b111000);
    go_idle(80);
    checks++;
    if (frame_cnt - f0 != 0 || lost_cnt - l0 != 1) begin
      errors++;
      $display("FAIL midreset_frame: got frames=%0d lost=%0d, want 0 1", frame_cnt - f0, lost_cnt - l0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_seg = 7'h00;
    i_seg_dp = 1'b0;
    i_seg_enb = 6'h3F;
    @(negedge clk);
    test_reset;
    test_frame;
    test_short_dwell;
    test_bad_pattern;
    test_enb_err;
    test_timeout;
    test_reset_midframe;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
